// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int MASK_W     = 8;
  localparam int INSN_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_MEM,
    BUSY_IF,
    DRAIN
  } arb_state_t;

  // Pick the 32-bit instruction word out of a 64-bit beat using address bit 2.
  function automatic logic [INSN_W-1:0] insn_slice(input logic [DATA_W_DEF-1:0] beat,
                                                   input logic                  hi_word);
    return hi_word ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one MMU port between IF and MEM (MEM wins), one transaction at a time; latency 2 + MMU wait.
// Port request is held until port_ready; requesters see stalls until their registered ready pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [INSN_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [MASK_W-1:0] mem_wmask,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              port_valid,
  output logic              port_we,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  output logic [MASK_W-1:0] port_wmask,
  input  logic              port_ready,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_port_we;
  logic [ADDR_W-1:0] r_port_addr;
  logic [DATA_W-1:0] r_port_wdata;
  logic [MASK_W-1:0] r_port_wmask;
  logic              r_if_ready;
  logic              r_mem_ready;
  logic [INSN_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;

  logic w_mem_take;
  logic w_if_take;
  logic w_load_mem;
  logic w_load_if;
  logic w_mem_done;
  logic w_if_done;

  // A requester in its ready cycle has just been served; its held req is not a new request.
  assign w_mem_take = mem_req && !r_mem_ready;
  assign w_if_take  = if_req && !if_flush && !r_if_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load_mem = 1'b0;
    w_load_if  = 1'b0;
    w_mem_done = 1'b0;
    w_if_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_take) begin
          w_load_mem = 1'b1;
          w_next     = BUSY_MEM;
        end else if (w_if_take) begin
          w_load_if = 1'b1;
          w_next    = BUSY_IF;
        end
      end
      BUSY_MEM: begin
        if (port_ready) begin
          w_mem_done = 1'b1;
          w_next     = IDLE;
        end
      end
      BUSY_IF: begin
        if (port_ready) begin
          w_if_done = !if_flush;
          w_next    = IDLE;
        end else if (if_flush) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        // The MMU transaction runs to completion; its data is simply dropped.
        if (port_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_port_we    <= 1'b0;
      r_port_addr  <= '0;
      r_port_wdata <= '0;
      r_port_wmask <= '0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      r_if_ready  <= w_if_done;
      r_mem_ready <= w_mem_done;
      if (w_load_mem) begin
        r_port_we    <= mem_we;
        r_port_addr  <= mem_addr;
        r_port_wdata <= mem_wdata;
        r_port_wmask <= mem_we ? mem_wmask : '0;
      end else if (w_load_if) begin
        r_port_we    <= 1'b0;
        r_port_addr  <= if_addr;
        r_port_wdata <= '0;
        r_port_wmask <= '0;
      end
      if (w_mem_done) begin
        r_mem_rdata <= port_rdata;
      end
      if (w_if_done) begin
        r_if_rdata <= insn_slice(port_rdata, r_port_addr[2]);
      end
    end
  end

  assign port_valid = (r_state != IDLE);
  assign port_we    = r_port_we;
  assign port_addr  = r_port_addr;
  assign port_wdata = r_port_wdata;
  assign port_wmask = r_port_wmask;
  assign if_ready   = r_if_ready;
  assign if_rdata   = r_if_rdata;
  assign mem_ready  = r_mem_ready;
  assign mem_rdata  = r_mem_rdata;
  assign stall_if   = if_req && !r_if_ready;
  assign stall_mem  = mem_req && !r_mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int OWN_NONE = 0;
  localparam int OWN_MEM  = 1;
  localparam int OWN_IF   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [7:0]  mem_wmask = '0;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        port_valid;
  logic        port_we;
  logic [63:0] port_addr;
  logic [63:0] port_wdata;
  logic [7:0]  port_wmask;
  logic        port_ready = 1'b0;
  logic [63:0] port_rdata = '0;
  logic        stall_if;
  logic        stall_mem;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .port_valid(port_valid),
    .port_we   (port_we),
    .port_addr (port_addr),
    .port_wdata(port_wdata),
    .port_wmask(port_wmask),
    .port_ready(port_ready),
    .port_rdata(port_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%h, expected 0x%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Transaction-level model: who owns the port, whether the fetch was cancelled,
  // what was issued, and what each requester has been handed back.
  int          m_owner = OWN_NONE;
  bit          m_cancel = 1'b0;
  logic        m_we = 1'b0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wmask = '0;
  logic        m_if_ready = 1'b0;
  logic        m_mem_ready = 1'b0;
  logic [31:0] m_if_rdata = '0;
  logic [63:0] m_mem_rdata = '0;

  always @(posedge clk or negedge rst) begin
    logic rdy_m;
    logic rdy_i;
    if (!rst) begin
      m_owner = OWN_NONE; m_cancel = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wmask = '0;
      m_if_ready = 1'b0; m_mem_ready = 1'b0; m_if_rdata = '0; m_mem_rdata = '0;
    end else begin
      rdy_m = 1'b0;
      rdy_i = 1'b0;
      if (m_owner == OWN_NONE) begin
        if (mem_req && !m_mem_ready) begin
          m_owner = OWN_MEM;
          m_we    = mem_we;
          m_addr  = mem_addr;
          m_wdata = mem_wdata;
          m_wmask = mem_we ? mem_wmask : 8'h00;
        end else if (if_req && !if_flush && !m_if_ready) begin
          m_owner = OWN_IF;
          m_we    = 1'b0;
          m_addr  = if_addr;
          m_wmask = 8'h00;
        end
      end else if (port_ready) begin
        if (m_owner == OWN_MEM) begin
          m_mem_rdata = port_rdata;
          rdy_m = 1'b1;
        end else if (!m_cancel && !if_flush) begin
          m_if_rdata = m_addr[2] ? port_rdata[63:32] : port_rdata[31:0];
          rdy_i = 1'b1;
        end
        m_owner  = OWN_NONE;
        m_cancel = 1'b0;
      end else if (m_owner == OWN_IF && if_flush) begin
        m_cancel = 1'b1;
      end
      m_mem_ready = rdy_m;
      m_if_ready  = rdy_i;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("port_valid", 64'(port_valid), 64'(m_owner != OWN_NONE));
      chk("if_ready", 64'(if_ready), 64'(m_if_ready));
      chk("mem_ready", 64'(mem_ready), 64'(m_mem_ready));
      chk("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
      chk("mem_rdata", mem_rdata, m_mem_rdata);
      chk("stall_if", 64'(stall_if), 64'(if_req && !m_if_ready));
      chk("stall_mem", 64'(stall_mem), 64'(mem_req && !m_mem_ready));
      if (m_owner != OWN_NONE) begin
        chk("port_addr", port_addr, m_addr);
        chk("port_we", 64'(port_we), 64'(m_we));
        chk("port_wmask", 64'(port_wmask), 64'(m_wmask));
        if (m_we) chk("port_wdata", port_wdata, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int mmu_wait = 0;
  bit mmu_busy = 1'b0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_port_valid", 64'(port_valid), 64'd0);
    chk("rst_port_we", 64'(port_we), 64'd0);
    chk("rst_port_addr", port_addr, 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    rst = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Load alone
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h1000;
    #1;
    chk("ld_stall_c0", 64'(stall_mem), 64'd1);
    chk("ld_valid_c0", 64'(port_valid), 64'd0);
    tick();
    chk("ld_valid_c1", 64'(port_valid), 64'd1);
    chk("ld_addr_c1", port_addr, 64'h1000);
    chk("ld_wmask_c1", 64'(port_wmask), 64'd0);
    chk("ld_stall_c1", 64'(stall_mem), 64'd1);
    port_ready = 1'b1; port_rdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    chk("ld_ready_c2", 64'(mem_ready), 64'd1);
    chk("ld_rdata_c2", mem_rdata, 64'hDEADBEEF_CAFEF00D);
    chk("ld_stall_c2", 64'(stall_mem), 64'd0);
    port_ready = 1'b0; mem_req = 1'b0;
    tick();
    chk("ld_ready_c3", 64'(mem_ready), 64'd0);
    chk("ld_rdata_hold", mem_rdata, 64'hDEADBEEF_CAFEF00D);

    // Contention: store wins, then fetch; then fetch slices
    if_req = 1'b1; if_addr = 64'h40;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h2000; mem_wdata = 64'h11; mem_wmask = 8'h01;
    tick();
    chk("ct_we", 64'(port_we), 64'd1);
    chk("ct_addr", port_addr, 64'h2000);
    chk("ct_wmask", 64'(port_wmask), 64'h01);
    chk("ct_wdata", port_wdata, 64'h11);
    port_ready = 1'b1; port_rdata = 64'h0;
    tick();
    chk("ct_mem_ready", 64'(mem_ready), 64'd1);
    chk("ct_valid_gap", 64'(port_valid), 64'd0);
    mem_req = 1'b0; port_ready = 1'b0;
    tick();
    chk("ct_if_valid", 64'(port_valid), 64'd1);
    chk("ct_if_addr", port_addr, 64'h40);
    chk("ct_if_wmask", 64'(port_wmask), 64'd0);
    port_ready = 1'b1; port_rdata = 64'h00000013_00A00093;
    tick();
    chk("sl_lo_ready", 64'(if_ready), 64'd1);
    chk("sl_lo_data", 64'(if_rdata), 64'h00A00093);
    if_addr = 64'h4; port_ready = 1'b0;
    tick();
    chk("sl_gap_valid", 64'(port_valid), 64'd0);
    tick();
    chk("sl_hi_addr", port_addr, 64'h4);
    port_ready = 1'b1;
    tick();
    chk("sl_hi_ready", 64'(if_ready), 64'd1);
    chk("sl_hi_data", 64'(if_rdata), 64'h00000013);
    if_req = 1'b0; port_ready = 1'b0;
    tick();

    // Flush in flight with a 3-cycle MMU wait
    if_req = 1'b1; if_addr = 64'h100;
    tick();
    chk("fl_valid_c1", 64'(port_valid), 64'd1);
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    chk("fl_valid_c2", 64'(port_valid), 64'd1);
    if_flush = 1'b0; if_req = 1'b1; if_addr = 64'h200;
    tick();
    chk("fl_valid_c3", 64'(port_valid), 64'd1);
    tick();
    chk("fl_addr_c4", port_addr, 64'h100);
    port_ready = 1'b1; port_rdata = rnd64();
    tick();
    chk("fl_no_ready", 64'(if_ready), 64'd0);
    chk("fl_idle", 64'(port_valid), 64'd0);
    port_ready = 1'b0;
    tick();
    chk("fl_new_addr", port_addr, 64'h200);
    port_ready = 1'b1;
    tick();
    chk("fl_new_ready", 64'(if_ready), 64'd1);
    if_req = 1'b0; port_ready = 1'b0;
    tick();

    // Flush coincident with port_ready
    if_req = 1'b1; if_addr = 64'h300;
    tick();
    if_flush = 1'b1; port_ready = 1'b1; if_req = 1'b0;
    tick();
    chk("fc_no_ready", 64'(if_ready), 64'd0);
    chk("fc_idle", 64'(port_valid), 64'd0);
    if_flush = 1'b0; port_ready = 1'b0;
    tick();

    // Async reset during BUSY_MEM
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h3000; mem_wdata = 64'h55; mem_wmask = 8'hFF;
    tick();
    chk("ar_valid_pre", 64'(port_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(port_valid), 64'd0);
    chk("ar_we", 64'(port_we), 64'd0);
    chk("ar_addr", port_addr, 64'd0);
    chk("ar_wmask", 64'(port_wmask), 64'd0);
    chk("ar_mem_rdata", mem_rdata, 64'd0);
    chk("ar_if_rdata", 64'(if_rdata), 64'd0);
    mem_req = 1'b0;
    #3;
    rst = 1'b1;
    tick();
    chk("ar_idle", 64'(port_valid), 64'd0);

    // Randomized traffic with a randomly-waiting MMU
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (m_owner != OWN_NONE) begin
        if (!mmu_busy) begin
          mmu_busy = 1'b1;
          mmu_wait = $urandom_range(0, 3);
        end
        if (mmu_wait == 0) begin
          port_ready = 1'b1;
          port_rdata = rnd64();
          mmu_busy = 1'b0;
        end else begin
          port_ready = 1'b0;
          mmu_wait--;
        end
      end else begin
        mmu_busy = 1'b0;
        port_ready = ($urandom_range(0, 15) == 0);
        port_rdata = rnd64();
      end
      if (!(mem_req && !m_mem_ready)) begin
        mem_req = ($urandom_range(0, 2) == 0);
        mem_we = $urandom_range(0, 1) == 1;
        mem_addr = rnd64();
        mem_wdata = rnd64();
        mem_wmask = 8'($urandom);
      end
      if_flush = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        if_flush = 1'b1;
        if_req = $urandom_range(0, 1) == 1;
        if_addr = rnd64() & ~64'h3;
      end else if (!(if_req && !m_if_ready)) begin
        if_req = $urandom_range(0, 1) == 1;
        if_addr = rnd64() & ~64'h3;
      end
    end

    if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0; port_ready = 1'b0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
